ex01_checker: RTL and testbench
===============================

# ex01_checker

Synthesizable response checker for the ex01 three-input/two-output logic block, and the receiving end of the ex01 stimulus sequence. It observes the applied vector {A,B,C} and the block's response {P,Q}, and waits a settle interval after every vector change. It then compares the response against a parameterized truth table and keeps pass/fail counts, a vector-coverage bitmap and a record of the first failure. It sits beside ex01, either in the bench or on-chip as a built-in self-check.

## Interface
- EXP_P, default 8'hC0: expected P indexed by {A,B,C} (bit i = expected P for vector i).
- EXP_Q, default 8'h96: expected Q indexed by {A,B,C}.
- SETTLE, default 4: clock cycles a vector must be stable before comparison; legal range 1..255.
- CNT_W, default 8: width of the pass/fail counters.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms the checker.
- A, B, C  in  1 each  observed stimulus, synchronous to clk.
- P, Q  in  1 each  observed ex01 response, synchronous to clk.
- busy  out  1  checker armed and running.
- done  out  1  all 8 vectors covered.
- pass_cnt  out  CNT_W  saturating count of matching comparisons.
- fail_cnt  out  CNT_W  saturating count of mismatching comparisons.
- cov  out  8  bit i set once vector i has been compared.
- err  out  1  sticky; set on the first mismatch.
- first_fail  out  5  {A,B,C,P,Q} captured at the first mismatch.

## Operation
- States:
  - IDLE: wait for start.
  - SETTLE: count the stability interval.
  - COMPARE: one cycle; check and update.
  - WAIT: watch for the next vector change.
  - DONE: coverage complete.
- IDLE --start--> SETTLE. The start edge clears counters, cov, err and first_fail, loads the current {A,B,C} into the vector register, and loads the timer with SETTLE-1.
- In SETTLE, the timer decrements each cycle.
  - If {A,B,C} differs from the vector register, the register and timer reload and the state stays SETTLE (glitch filter).
  - When the timer reaches 0 with the vector unchanged, go to COMPARE.
- In COMPARE, with idx = vector register:
  - match = (P == EXP_P[idx]) && (Q == EXP_Q[idx]).
  - On a match, pass_cnt increments; otherwise fail_cnt increments. Both counters saturate at all-ones.
  - cov[idx] is set.
  - On a mismatch with err == 0: err sets and first_fail latches {idx,P,Q}. Later mismatches leave first_fail unchanged.
  - Next state is DONE if cov (including this update) == 8'hFF, otherwise WAIT.
- In WAIT, a change of {A,B,C} reloads the vector register and timer and moves to SETTLE. Re-entering an already-covered vector is compared and counted again.
- In DONE, busy = 0, done = 1, and all results hold. A start pulse re-arms the checker exactly as from IDLE.
- Start in SETTLE, COMPARE or WAIT is ignored.
- A vector change during COMPARE is picked up by WAIT on the next cycle, because the comparison uses the registered vector.

## Timing
- Reset values: busy = 0, done = 0, pass_cnt = 0, fail_cnt = 0, cov = 0, err = 0, first_fail = 0; state IDLE.
- Assertion of rst mid-run returns every output to its reset value immediately (asynchronously).
- busy rises on the edge that samples start and falls on the edge that enters DONE. done rises on that same edge.
- Latency: a vector first sampled at edge n, and stable afterwards, is compared in the cycle after edge n+SETTLE. Its counters and cov update at edge n+SETTLE+1.
- With SETTLE = 1, COMPARE follows the loading edge directly.
- P and Q are sampled only in COMPARE. Values before that point are don't-care.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared include ex01_defs.vh holds:
  - the state encoding localparams (IDLE, SETTLE, COMPARE, WAIT, DONE, 3-bit);
  - VEC_W = 3;
  - the default EXP_P/EXP_Q constants;
  - COV_ALL = 8'hFF.
- One sub-module, ex01_settle_timer, implements the reloadable 8-bit down-counter with load, enable and zero outputs.
- The top level holds the FSM, comparator, counters and capture registers.

## Test plan
- **Reset mid-run:** assert rst during SETTLE -> all outputs 0 within the same cycle; the checker stays in IDLE after release until start.
- **Full clean sweep:** SETTLE = 4; apply vectors 0..7, 20 cycles each, with ex01 connected -> pass_cnt = 8, fail_cnt = 0, cov = 8'hFF, err = 0. done rises 5 cycles after vector 7 is first sampled.
- **Single fault:** invert Q while {A,B,C} = 3'b101 -> fail_cnt = 1, pass_cnt = 7, err = 1, first_fail = 5'b10101.
- **Glitch filter:** change the vector from 3'b001 to 3'b010 after 2 cycles of SETTLE, then hold -> only 3'b010 is counted. cov = 8'b00000100 and pass_cnt = 1 after the first comparison.
- **Saturation:** CNT_W = 2; alternate vectors 0 and 1 six times -> pass_cnt holds at 3, cov = 8'h03, done stays 0.
- **Start handling:** a start pulse while busy has no effect on counts. A start pulse in DONE clears all results and sets busy = 1 on the next edge.

Source files
------------

// File: rtl/ex01_checker_pkg.sv
// Shared constants for the ex01 response checker: state encoding, vector width,
// default ex01 truth tables (P = A&B, Q = A^B^C) and the full-coverage mask.
package ex01_checker_pkg;

  localparam int         VEC_W     = 3;
  localparam logic [7:0] EXP_P_DEF = 8'hC0;
  localparam logic [7:0] EXP_Q_DEF = 8'h96;
  localparam logic [7:0] COV_ALL   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_COMPARE = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/ex01_settle_timer.sv
// Reloadable 8-bit down-counter; load wins over enable and the count stops at zero.
// Latency: zero is registered-count decode, valid the cycle after load; no backpressure.
module ex01_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/ex01_checker.sv
// Response checker for ex01: settles each vector, compares {P,Q} against EXP_P/EXP_Q.
// Latency: vector sampled at edge n updates results at edge n+SETTLE+1; no backpressure.
module ex01_checker
  import ex01_checker_pkg::*;
#(
  parameter logic [7:0] EXP_P  = EXP_P_DEF,
  parameter logic [7:0] EXP_Q  = EXP_Q_DEF,
  parameter int         SETTLE = 4,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             P,
  input  logic             Q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       cov,
  output logic             err,
  output logic [4:0]       first_fail
);

  localparam logic [7:0] TMR_INIT = 8'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec_r;
  logic [VEC_W-1:0] vec_in;
  logic             vec_chg;
  logic             tmr_load, tmr_en, tmr_zero;
  logic             vec_load, clr, do_cmp;
  logic             match;
  logic [7:0]       cov_nxt;

  assign vec_in  = {A, B, C};
  assign vec_chg = (vec_in != vec_r);
  assign match   = (P == EXP_P[vec_r]) && (Q == EXP_Q[vec_r]);
  assign cov_nxt = cov | (8'd1 << vec_r);

  ex01_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (TMR_INIT),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      vec_r <= '0;
    end else begin
      state <= state_nxt;
      if (vec_load) vec_r <= vec_in;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    vec_load  = 1'b0;
    clr       = 1'b0;
    do_cmp    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_SETTLE;
          tmr_load  = 1'b1;
          vec_load  = 1'b1;
          clr       = 1'b1;
        end
      end
      S_SETTLE: begin
        // A change restarts the interval even if the timer has just expired.
        if (vec_chg) begin
          tmr_load = 1'b1;
          vec_load = 1'b1;
        end else if (tmr_zero) begin
          state_nxt = S_COMPARE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_COMPARE: begin
        do_cmp    = 1'b1;
        state_nxt = (cov_nxt == COV_ALL) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (vec_chg) begin
          state_nxt = S_SETTLE;
          tmr_load  = 1'b1;
          vec_load  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      cov        <= '0;
      err        <= 1'b0;
      first_fail <= '0;
    end else if (clr) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      cov        <= '0;
      err        <= 1'b0;
      first_fail <= '0;
    end else if (do_cmp) begin
      cov <= cov_nxt;
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!err) begin
          err        <= 1'b1;
          first_fail <= {vec_r, P, Q};
        end
      end
    end
  end

  assign busy = (state == S_SETTLE) || (state == S_COMPARE) || (state == S_WAIT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_ex01_checker.sv
// Directed bench for ex01_checker: table-driven sweeps plus hand-written corner sequences.
module tb_ex01_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic qinv = 1'b0;
  logic p, q;

  logic       busy, done, err;
  logic [7:0] pass_cnt, fail_cnt, cov;
  logic [4:0] first_fail;

  logic       s_busy, s_done, s_err;
  logic [1:0] s_pass, s_fail;
  logic [7:0] s_cov;
  logic [4:0] s_ff;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural ex01: P = A&B, Q = A^B^C, with an optional fault on Q.
  assign p = a & b;
  assign q = (a ^ b ^ c) ^ qinv;

  ex01_checker dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C(c), .P(p), .Q(q),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .cov(cov), .err(err), .first_fail(first_fail)
  );

  ex01_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C(c), .P(p), .Q(q),
    .busy(s_busy), .done(s_done), .pass_cnt(s_pass), .fail_cnt(s_fail),
    .cov(s_cov), .err(s_err), .first_fail(s_ff)
  );

  typedef struct {
    logic       arm;
    logic [2:0] abc;
    logic       qinv;
    logic [7:0] exp_pass;
    logic [7:0] exp_fail;
    logic [7:0] exp_cov;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic arm, logic [2:0] abc, logic qi,
                              logic [7:0] ep, logic [7:0] ef, logic [7:0] ec);
    vec_t v;
    v.arm = arm; v.abc = abc; v.qinv = qi;
    v.exp_pass = ep; v.exp_fail = ef; v.exp_cov = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(logic [2:0] v);
    {a, b, c} = v;
  endtask

  task automatic idle_cycles(int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    // Clean sweep 0..7 after arming, then a re-armed sweep with Q faulted on vector 5.
    tbl[0]  = mk(1'b1, 3'd0, 1'b0, 8'd1, 8'd0, 8'h01);
    tbl[1]  = mk(1'b0, 3'd1, 1'b0, 8'd2, 8'd0, 8'h03);
    tbl[2]  = mk(1'b0, 3'd2, 1'b0, 8'd3, 8'd0, 8'h07);
    tbl[3]  = mk(1'b0, 3'd3, 1'b0, 8'd4, 8'd0, 8'h0F);
    tbl[4]  = mk(1'b0, 3'd4, 1'b0, 8'd5, 8'd0, 8'h1F);
    tbl[5]  = mk(1'b0, 3'd5, 1'b0, 8'd6, 8'd0, 8'h3F);
    tbl[6]  = mk(1'b0, 3'd6, 1'b0, 8'd7, 8'd0, 8'h7F);
    tbl[7]  = mk(1'b0, 3'd7, 1'b0, 8'd8, 8'd0, 8'hFF);
    tbl[8]  = mk(1'b1, 3'd0, 1'b0, 8'd1, 8'd0, 8'h01);
    tbl[9]  = mk(1'b0, 3'd1, 1'b0, 8'd2, 8'd0, 8'h03);
    tbl[10] = mk(1'b0, 3'd2, 1'b0, 8'd3, 8'd0, 8'h07);
    tbl[11] = mk(1'b0, 3'd3, 1'b0, 8'd4, 8'd0, 8'h0F);
    tbl[12] = mk(1'b0, 3'd4, 1'b0, 8'd5, 8'd0, 8'h1F);
    tbl[13] = mk(1'b0, 3'd5, 1'b1, 8'd5, 8'd1, 8'h3F);
    tbl[14] = mk(1'b0, 3'd6, 1'b0, 8'd6, 8'd1, 8'h7F);
    tbl[15] = mk(1'b0, 3'd7, 1'b0, 8'd7, 8'd1, 8'hFF);

    // Reset state
    idle_cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_cov", cov, 0);
    chk("rst_err", err, 0);
    chk("rst_ff", first_fail, 0);
    rst = 1'b0;
    idle_cycles(2);

    // Table-driven sweeps, 20 cycles per vector
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_vec(tbl[i].abc);
      qinv  = tbl[i].qinv;
      start = tbl[i].arm;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (i == 7 && k == 5) chk("done_before_lat", done, 0);
        if (i == 7 && k == 6) chk("done_at_lat", done, 1);
        if (tbl[i].arm && k == 1) chk($sformatf("busy_arm_%0d", i), busy, 1);
      end
      chk($sformatf("pass_row%0d", i), pass_cnt, tbl[i].exp_pass);
      chk($sformatf("fail_row%0d", i), fail_cnt, tbl[i].exp_fail);
      chk($sformatf("cov_row%0d", i), cov, tbl[i].exp_cov);
      if (i == 7) begin
        chk("sweep_err", err, 0);
        chk("sweep_busy", busy, 0);
      end
    end
    chk("fault_err", err, 1);
    chk("fault_ff", first_fail, 5'b10101);
    chk("fault_done", done, 1);
    chk("fault_busy", busy, 0);

    // Start in DONE clears everything and re-arms on the next edge
    @(negedge clk);
    set_vec(3'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rearm_busy", busy, 1);
    chk("rearm_done", done, 0);
    chk("rearm_pass", pass_cnt, 0);
    chk("rearm_fail", fail_cnt, 0);
    chk("rearm_cov", cov, 0);
    chk("rearm_err", err, 0);
    chk("rearm_ff", first_fail, 0);
    idle_cycles(19);
    chk("rearm_pass1", pass_cnt, 1);

    // Start while in WAIT, then while in SETTLE: both ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(19);
    chk("ign_wait_pass", pass_cnt, 1);
    chk("ign_wait_cov", cov, 8'h01);
    chk("ign_wait_busy", busy, 1);
    set_vec(3'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(20);
    chk("ign_settle_pass", pass_cnt, 2);
    chk("ign_settle_cov", cov, 8'h03);

    // Reset asserted mid-SETTLE takes effect without a clock edge
    set_vec(3'd3);
    idle_cycles(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pass", pass_cnt, 0);
    chk("mid_rst_cov", cov, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(5);
    set_vec(3'd5);
    idle_cycles(10);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cov", cov, 0);
    chk("post_rst_pass", pass_cnt, 0);

    // Glitch filter: 001 abandoned two cycles into SETTLE, 010 then held
    set_vec(3'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    set_vec(3'd2);
    idle_cycles(20);
    chk("glitch_cov", cov, 8'b00000100);
    chk("glitch_pass", pass_cnt, 1);
    chk("glitch_fail", fail_cnt, 0);

    // Saturation with CNT_W = 2: six comparisons alternating vectors 0 and 1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      set_vec((r % 2 == 0) ? 3'd0 : 3'd1);
      start = (r == 0);
      @(negedge clk);
      start = 1'b0;
      idle_cycles(9);
    end
    chk("sat_pass", s_pass, 2'd3);
    chk("sat_fail", s_fail, 2'd0);
    chk("sat_cov", s_cov, 8'h03);
    chk("sat_done", s_done, 0);
    chk("sat_wide_pass", pass_cnt, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
